// File: rtl/kb_event_fifo_if.sv
// kb_event_fifo_if: bus bundle between PS/2 receiver, Z180 decode and kb_event_fifo.
// master = receiver/bus side (drives strobes), slave = kb_event_fifo.
//
// Signals:
//   CODE_VALID  one-cycle strobe, CODE holds a completed scan-code byte
//   CODE[7:0]   scan-code byte
//   SEL         active-high chip select
//   A0          register select: 0 = data, 1 = status
//   RD_STB      one-cycle read strobe, synchronous to CLK
//   DOUT[7:0]   read data (combinational)
//   DOUT_EN     tri-state enable, follows SEL
//   IRQ         level interrupt, high while events are queued

interface kb_event_fifo_if;
   logic       CODE_VALID;
   logic [7:0] CODE;
   logic       SEL;
   logic       A0;
   logic       RD_STB;
   logic [7:0] DOUT;
   logic       DOUT_EN;
   logic       IRQ;

   modport master (
      output CODE_VALID, CODE, SEL, A0, RD_STB,
      input  DOUT, DOUT_EN, IRQ
   );

   modport slave (
      input  CODE_VALID, CODE, SEL, A0, RD_STB,
      output DOUT, DOUT_EN, IRQ
   );
endinterface

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: folds PS/2 E0/F0 prefixes into key events, queues them
// in a small FIFO and exposes data/status registers plus a level IRQ.
//
// Ports:
//   CLK   system clock
//   RST   synchronous reset, active-high
//   bus   kb_event_fifo_if.slave (CODE_VALID, CODE, SEL, A0, RD_STB,
//         DOUT, DOUT_EN, IRQ)
// Parameters:
//   DEPTH FIFO entries (power of 2, 2..16), AW = log2(DEPTH)
// Entry format: {ext, brk, code[7:0]}
// Status byte:  {NE, OVF, FULL, ERR, 2'b00, head_ext, head_brk}
//
// Optional build macro KB_TYPEMATIC_FILTER_EN: suppresses key
// auto-repeat by dropping a make identical to the last pushed make.

module kb_event_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic           CLK,
   input  logic           RST,
   kb_event_fifo_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   state_t        state_q;

   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;

   logic          is_e0;
   logic          is_f0;
   logic          is_err;
   logic          is_key;
   logic          ev_ext;
   logic          ev_brk;
   logic [9:0]    ev;
   logic          filt;
   logic          push;
   logic          rd_data;
   logic          rd_stat;
   logic          empty;
   logic          full;
   logic          pop;
   logic          wr_en;
   logic          ovf_set;
   logic          err_set;
   logic [9:0]    head;
   logic [7:0]    stat;

   // ---------------- byte decode ----------------

   assign is_e0  = (bus.CODE == 8'hE0);
   assign is_f0  = (bus.CODE == 8'hF0);
   assign is_err = (bus.CODE == 8'h00) | (bus.CODE == 8'hFF);
   assign is_key = bus.CODE_VALID & ~is_e0 & ~is_f0 & ~is_err;

   assign ev_ext = (state_q == S_EXT) | (state_q == S_EXT_BRK);
   assign ev_brk = (state_q == S_BRK) | (state_q == S_EXT_BRK);
   assign ev     = {ev_ext, ev_brk, bus.CODE};

   // ---------------- prefix state machine ----------------

   // A fresh E0 or F0 restarts the prefix sequence from wherever it was;
   // only F0 directly after E0 builds the extended-break combination.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else if (bus.CODE_VALID) begin
         unique case (1'b1)
            is_err: state_q <= S_IDLE;
            is_e0:  state_q <= S_EXT;
            is_f0:  state_q <= (state_q == S_EXT) ? S_EXT_BRK : S_BRK;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------- typematic filter ----------------

`ifdef KB_TYPEMATIC_FILTER_EN
   logic [9:0] typ_q, typ_d;
   logic       typ_hit;

   // typ_q = {valid, ext, code} of the last make that entered the FIFO
   assign typ_hit = typ_q[9] &
                    (typ_q[8] == ev_ext) &
                    (typ_q[7:0] == bus.CODE);
   assign filt    = is_key & ~ev_brk & typ_hit;

   always_comb begin
      typ_d = typ_q;
      if (is_key & ev_brk & typ_hit) begin
         typ_d[9] = 1'b0;
      end else if (wr_en & ~ev_brk) begin
         typ_d = {1'b1, ev_ext, bus.CODE};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         typ_q <= '0;
      end else begin
         typ_q <= typ_d;
      end
   end
`else
   assign filt = 1'b0;
`endif

   // ---------------- FIFO control ----------------

   assign push    = is_key & ~filt;
   assign rd_data = bus.RD_STB & bus.SEL & ~bus.A0;
   assign rd_stat = bus.RD_STB & bus.SEL & bus.A0;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_FULL);

   // A pop frees the slot the push needs, so a full FIFO still accepts
   // a push when it is read on the same edge.
   assign pop     = rd_data & ~empty;
   assign wr_en   = push & (~full | pop);
   assign ovf_set = push & full & ~pop;
   assign err_set = bus.CODE_VALID & is_err;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Sticky flags: a set on the clearing edge takes priority.
   always_comb begin
      ovf_d = ovf_q;
      err_d = err_q;
      if (rd_stat) begin
         ovf_d = 1'b0;
         err_d = 1'b0;
      end
      if (ovf_set) begin
         ovf_d = 1'b1;
      end
      if (err_set) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   // Storage needs no reset: empty is tracked by cnt_q and the head
   // is masked while the FIFO is empty.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= ev;
      end
   end

   // ---------------- register read ----------------

   assign head = empty ? 10'h000 : mem_q[rd_ptr_q];
   assign stat = {~empty, ovf_q, full, err_q, 2'b00, head[9], head[8]};

   always_comb begin
      bus.DOUT = 8'h00;
      if (bus.SEL) begin
         bus.DOUT = bus.A0 ? stat : head[7:0];
      end
   end

   assign bus.DOUT_EN = bus.SEL;
   assign bus.IRQ     = ~empty;

endmodule

// File: tb/tb_kb_event_fifo.sv
// tb_kb_event_fifo: directed self-checking bench for kb_event_fifo.
// One task per scenario, each with inline expected-value checks.

`timescale 1ns/1ps

module tb_kb_event_fifo;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   kb_event_fifo_if bus ();

   kb_event_fifo #(
      .DEPTH (8),
      .AW    (3)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One bus cycle: drive at negedge, sample DOUT before the edge,
   // release everything just after the edge.
   task automatic step(input logic v, input logic [7:0] c,
                       input logic s, input logic a,
                       input logic r, output logic [7:0] d);
      @(negedge clk);
      bus.CODE_VALID = v;
      bus.CODE       = c;
      bus.SEL        = s;
      bus.A0         = a;
      bus.RD_STB     = r;
      #1 d = bus.DOUT;
      @(posedge clk);
      #1;
      bus.CODE_VALID = 1'b0;
      bus.CODE       = 8'h00;
      bus.SEL        = 1'b0;
      bus.A0         = 1'b0;
      bus.RD_STB     = 1'b0;
   endtask

   task automatic push(input logic [7:0] c);
      logic [7:0] d;
      step(1'b1, c, 1'b0, 1'b0, 1'b0, d);
   endtask

   task automatic rd(input logic a, output logic [7:0] d);
      step(1'b0, 8'h00, 1'b1, a, 1'b1, d);
   endtask

   task automatic peek(input logic a, output logic [7:0] d);
      step(1'b0, 8'h00, 1'b1, a, 1'b0, d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      n_checks++;
      if (bus.IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq: got %b want 0", bus.IRQ);
      end
      @(negedge clk);
      bus.SEL = 1'b0;
      #1;
      n_checks++;
      if (bus.DOUT !== 8'h00 || bus.DOUT_EN !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sel_low: dout %h en %b want 00 0",
                  bus.DOUT, bus.DOUT_EN);
      end
      bus.SEL = 1'b1;
      bus.A0  = 1'b1;
      #1;
      n_checks++;
      if (bus.DOUT !== 8'h00 || bus.DOUT_EN !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_status: dout %h en %b want 00 1",
                  bus.DOUT, bus.DOUT_EN);
      end
      bus.SEL = 1'b0;
      bus.A0  = 1'b0;
      // reset mid-sequence drops the queue and the pending prefix
      push(8'h15);
      push(8'hE0);
      do_reset();
      push(8'h1C);
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h80) begin
         n_fail++;
         $display("FAIL reset_mid_status: got %h want 80", d);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h1C) begin
         n_fail++;
         $display("FAIL reset_mid_data: got %h want 1c", d);
      end
   endtask

   task automatic test_single_make();
      logic [7:0] d;
      do_reset();
      push(8'h1C);
      n_checks++;
      if (bus.IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL make_irq: got %b want 1", bus.IRQ);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h80) begin
         n_fail++;
         $display("FAIL make_status: got %h want 80", d);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h1C || bus.IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL make_pop: data %h irq %b want 1c 0", d, bus.IRQ);
      end
   endtask

   task automatic test_ext_break();
      logic [7:0] d;
      do_reset();
      push(8'hE0);
      push(8'hF0);
      push(8'h75);
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h83) begin
         n_fail++;
         $display("FAIL extbrk_status: got %h want 83", d);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h75) begin
         n_fail++;
         $display("FAIL extbrk_data: got %h want 75", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++;
         $display("FAIL extbrk_one_entry: got %h want 00", d);
      end
   endtask

   task automatic test_prefix_restart();
      logic [7:0] d;
      do_reset();
      push(8'hF0);
      push(8'hE0);
      push(8'h6B);
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h82) begin
         n_fail++;
         $display("FAIL restart_status: got %h want 82", d);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h6B) begin
         n_fail++;
         $display("FAIL restart_data: got %h want 6b", d);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] d;
      logic [7:0] c;
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         c = 8'(i);
         push(c);
      end
      rd(1'b1, d);
      n_checks++;
      if (d !== 8'hE0) begin
         n_fail++;
         $display("FAIL ovf_status: got %h want e0", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'hA0) begin
         n_fail++;
         $display("FAIL ovf_cleared: got %h want a0", d);
      end
      for (int i = 1; i <= 8; i++) begin
         rd(1'b0, d);
         n_checks++;
         if (d !== 8'(i)) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got %h want %h", i, d, 8'(i));
         end
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++;
         $display("FAIL empty_read: got %h want 00", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++;
         $display("FAIL empty_status: got %h want 00", d);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] d;
      logic [7:0] want;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         push(8'(i));
      end
      step(1'b1, 8'h30, 1'b1, 1'b0, 1'b1, d);
      n_checks++;
      if (d !== 8'h01) begin
         n_fail++;
         $display("FAIL full_pp_data: got %h want 01", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'hA0) begin
         n_fail++;
         $display("FAIL full_pp_status: got %h want a0", d);
      end
      for (int i = 0; i < 8; i++) begin
         want = (i < 7) ? 8'(i + 2) : 8'h30;
         rd(1'b0, d);
         n_checks++;
         if (d !== want) begin
            n_fail++;
            $display("FAIL full_pp_drain%0d: got %h want %h", i, d, want);
         end
      end
      n_checks++;
      if (bus.IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pp_irq: got %b want 0", bus.IRQ);
      end
   endtask

   task automatic test_error();
      logic [7:0] d;
      do_reset();
      push(8'hF0);
      push(8'hFF);
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h10) begin
         n_fail++;
         $display("FAIL err_status: got %h want 10", d);
      end
      push(8'h1C);
      rd(1'b1, d);
      n_checks++;
      if (d !== 8'h90) begin
         n_fail++;
         $display("FAIL err_idle_push: got %h want 90", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h80) begin
         n_fail++;
         $display("FAIL err_clear: got %h want 80", d);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h1C) begin
         n_fail++;
         $display("FAIL err_data: got %h want 1c", d);
      end
      // error set on the clearing edge stays set
      push(8'h00);
      step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, d);
      n_checks++;
      if (d !== 8'h10) begin
         n_fail++;
         $display("FAIL err_pre_clear: got %h want 10", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h10) begin
         n_fail++;
         $display("FAIL err_set_wins: got %h want 10", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      do_reset();
      push(8'h11);
      step(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, d);
      n_checks++;
      if (d !== 8'h11) begin
         n_fail++;
         $display("FAIL b2b_pop: got %h want 11", d);
      end
      peek(1'b1, d);
      n_checks++;
      if (d !== 8'h80) begin
         n_fail++;
         $display("FAIL b2b_status: got %h want 80", d);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h22) begin
         n_fail++;
         $display("FAIL b2b_new_head: got %h want 22", d);
      end
      // empty FIFO: push accepted, pop ignored
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, d);
      n_checks++;
      if (d !== 8'h00 || bus.IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_empty: data %h irq %b want 00 1", d, bus.IRQ);
      end
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h33) begin
         n_fail++;
         $display("FAIL b2b_empty_data: got %h want 33", d);
      end
      // SEL low ignores RD_STB
      push(8'h44);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, d);
      rd(1'b0, d);
      n_checks++;
      if (d !== 8'h44) begin
         n_fail++;
         $display("FAIL sel_low_no_pop: got %h want 44", d);
      end
   endtask

   task automatic test_typematic();
      logic [7:0] d;
      int         n;
      int         want;
      do_reset();
      push(8'h1C);
      push(8'h1C);
      push(8'h1C);
      push(8'hF0);
      push(8'h1C);
`ifdef KB_TYPEMATIC_FILTER_EN
      want = 2;
`else
      want = 4;
`endif
      n = 0;
      for (int i = 0; i < 16; i++) begin
         peek(1'b1, d);
         if (d[7] !== 1'b1) break;
         rd(1'b0, d);
         n++;
      end
      n_checks++;
      if (n != want) begin
         n_fail++;
         $display("FAIL typematic_entries: got %0d want %0d", n, want);
      end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b1;
      bus.CODE_VALID = 1'b0;
      bus.CODE       = 8'h00;
      bus.SEL        = 1'b0;
      bus.A0         = 1'b0;
      bus.RD_STB     = 1'b0;
      test_reset();
      test_single_make();
      test_ext_break();
      test_prefix_restart();
      test_overflow();
      test_full_push_pop();
      test_error();
      test_back_to_back();
      test_typematic();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
